// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART transmitter types, word-length codes and defaults
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int c_oversample_default = 16;

    localparam logic [1:0] c_wls_5 = 2'd0;
    localparam logic [1:0] c_wls_6 = 2'd1;
    localparam logic [1:0] c_wls_7 = 2'd2;
    localparam logic [1:0] c_wls_8 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Mask selecting the data bits that are actually sent for a word length
    function automatic logic [7:0] wls_mask(input logic [1:0] wls);
        logic [7:0] mask;
        case (wls)
            c_wls_5: mask = 8'h1F;
            c_wls_6: mask = 8'h3F;
            c_wls_7: mask = 8'h7F;
            c_wls_8: mask = 8'hFF;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_thr_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_thr_tx_if
// Description : Character write handshake into the transmit holding register
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_thr_tx_if;

    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;

    modport master (
        output i_data,
        output i_valid,
        input  o_ready
    );

    modport slave (
        input  i_data,
        input  i_valid,
        output o_ready
    );

endinterface
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : Divisor-driven tick generator with restart and zero-divisor stall
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen (
    input  wire        i_sys_clk,
    input  wire        i_sys_rst,
    input  wire        i_restart,
    input  wire [15:0] i_divisor,
    output logic       o_tick
);

    logic [15:0] r_presc;
    logic        w_stall;

    assign w_stall = (i_divisor == 16'd0);
    assign o_tick  = !w_stall && (r_presc == (i_divisor - 16'd1));

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_presc <= 16'd0;
        end else if (i_restart || o_tick) begin
            r_presc <= 16'd0;
        end else if (!w_stall) begin
            r_presc <= r_presc + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_thr_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_thr_tx
// Description : 16550-style transmitter: holding register, shifter, framing FSM
// Revision    : 1.0 - initial release
// ============================================================================
module uart_thr_tx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = c_oversample_default
) (
    input  wire         i_sys_clk,
    input  wire         i_sys_rst,
    uart_thr_tx_if.slave bus,
    input  wire  [15:0] i_divisor,
    input  wire  [1:0]  i_wls,
    input  wire         i_stb,
    input  wire         i_pen,
    input  wire         i_eps,
    input  wire         i_sp,
    input  wire         i_bc,
    output logic        o_tx,
    output logic        o_thre,
    output logic        o_temt
);

    localparam int c_cnt_w = $clog2(2 * OVERSAMPLE);
    localparam logic [c_cnt_w-1:0] c_last_1  = c_cnt_w'(OVERSAMPLE - 1);
    localparam logic [c_cnt_w-1:0] c_last_15 = c_cnt_w'(OVERSAMPLE + OVERSAMPLE / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_last_2  = c_cnt_w'(2 * OVERSAMPLE - 1);

    uart_state_e         r_state;
    logic                r_thr_full;
    logic [7:0]          r_thr_data;
    logic [7:0]          r_shift;
    logic [2:0]          r_bit_idx;
    logic [c_cnt_w-1:0]  r_tick_cnt;
    logic                r_tx;
    logic [15:0]         r_div;
    logic [1:0]          r_wls;
    logic                r_stb;
    logic                r_pen;
    logic                r_par_bit;

    logic                w_tick;
    logic                w_write;
    logic                w_load;
    logic                w_bit_last;
    logic [c_cnt_w-1:0]  w_last_cnt;
    logic [2:0]          w_last_idx;
    logic [7:0]          w_masked;
    logic                w_par_bit;

    uart_baud_gen u_baud_gen (
        .i_sys_clk (i_sys_clk),
        .i_sys_rst (i_sys_rst),
        .i_restart (w_load),
        .i_divisor (r_div),
        .o_tick    (w_tick)
    );

    // Stop length depends on the latched stb/wls: 1, 1.5 or 2 bit periods
    always_comb begin
        w_last_cnt = c_last_1;
        if (r_state == ST_STOP) begin
            if (!r_stb) begin
                w_last_cnt = c_last_1;
            end else if (r_wls == c_wls_5) begin
                w_last_cnt = c_last_15;
            end else begin
                w_last_cnt = c_last_2;
            end
        end
    end

    assign w_bit_last = (r_tick_cnt == w_last_cnt);
    assign w_last_idx = {1'b0, r_wls} + 3'd4;
    assign w_write    = bus.i_valid && !r_thr_full;
    assign w_load     = r_thr_full &&
                        ((r_state == ST_IDLE) ||
                         ((r_state == ST_STOP) && w_tick && w_bit_last));

    assign w_masked  = r_thr_data & wls_mask(i_wls);
    assign w_par_bit = i_sp ? ~i_eps : (i_eps ? ^w_masked : ~^w_masked);

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_state    <= ST_IDLE;
            r_thr_full <= 1'b0;
            r_thr_data <= 8'd0;
            r_shift    <= 8'd0;
            r_bit_idx  <= 3'd0;
            r_tick_cnt <= '0;
            r_tx       <= 1'b1;
            r_div      <= 16'd0;
            r_wls      <= 2'd0;
            r_stb      <= 1'b0;
            r_pen      <= 1'b0;
            r_par_bit  <= 1'b0;
        end else begin
            if (w_write) begin
                r_thr_full <= 1'b1;
                r_thr_data <= bus.i_data;
            end else if (w_load) begin
                r_thr_full <= 1'b0;
            end

            if (w_load) begin
                r_state    <= ST_START;
                r_tx       <= 1'b0;
                r_shift    <= r_thr_data;
                r_tick_cnt <= '0;
                r_div      <= i_divisor;
                r_wls      <= i_wls;
                r_stb      <= i_stb;
                r_pen      <= i_pen;
                r_par_bit  <= w_par_bit;
            end else if (w_tick && (r_state != ST_IDLE)) begin
                if (w_bit_last) begin
                    r_tick_cnt <= '0;
                    case (r_state)
                        ST_START: begin
                            r_state   <= ST_DATA;
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_idx <= 3'd0;
                        end
                        ST_DATA: begin
                            if (r_bit_idx == w_last_idx) begin
                                if (r_pen) begin
                                    r_state <= ST_PARITY;
                                    r_tx    <= r_par_bit;
                                end else begin
                                    r_state <= ST_STOP;
                                    r_tx    <= 1'b1;
                                end
                            end else begin
                                r_tx      <= r_shift[0];
                                r_shift   <= r_shift >> 1;
                                r_bit_idx <= r_bit_idx + 3'd1;
                            end
                        end
                        ST_PARITY: begin
                            r_state <= ST_STOP;
                            r_tx    <= 1'b1;
                        end
                        ST_STOP: begin
                            r_state <= ST_IDLE;
                            r_tx    <= 1'b1;
                        end
                        default: begin
                            r_state <= ST_IDLE;
                            r_tx    <= 1'b1;
                        end
                    endcase
                end else begin
                    r_tick_cnt <= r_tick_cnt + 1'b1;
                end
            end
        end
    end

    assign o_thre      = !r_thr_full;
    assign bus.o_ready = !r_thr_full;
    assign o_temt      = !r_thr_full && (r_state == ST_IDLE);
    assign o_tx        = r_tx & ~i_bc;

endmodule
`default_nettype wire

// File: tb/tb_uart_thr_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_thr_tx
// Description : Self-checking bench for uart_thr_tx against a frame-level model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_thr_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] divisor = 16'd1;
    logic [1:0]  wls = 2'd3;
    logic        stb = 1'b0, pen = 1'b0, eps = 1'b0, sp = 1'b0, bc = 1'b0;
    logic        tx, thre, temt;

    int n_tests = 0;
    int n_fail  = 0;

    uart_thr_tx_if bus ();

    uart_thr_tx #(.OVERSAMPLE(16)) dut (
        .i_sys_clk (clk),
        .i_sys_rst (rst),
        .bus       (bus),
        .i_divisor (divisor),
        .i_wls     (wls),
        .i_stb     (stb),
        .i_pen     (pen),
        .i_eps     (eps),
        .i_sp      (sp),
        .i_bc      (bc),
        .o_tx      (tx),
        .o_thre    (thre),
        .o_temt    (temt)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected line level per clock, counted from the load edge
    bit exp_wave[$];
    int exp_par_idx;
    int par_sample, ready0, ready50;

    task automatic check(input string name, input int act, input int exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    function automatic void build_wave(input logic [7:0] d, input logic [1:0] w, input bit p_en,
                                       input bit e, input bit s, input bit two_stop, input int dv,
                                       input bit append);
        int nb;
        int bt;
        int ones;
        int stop_clks;
        bit par;
        nb   = int'(w) + 5;
        bt   = 16 * dv;
        ones = 0;
        if (!append) exp_wave.delete();
        repeat (bt) exp_wave.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            repeat (bt) exp_wave.push_back(d[i]);
            ones += int'(d[i]);
        end
        exp_par_idx = bt * (1 + nb) + bt / 2;
        if (p_en) begin
            if (s)      par = !e;
            else if (e) par = (ones % 2) == 1;
            else        par = (ones % 2) == 0;
            repeat (bt) exp_wave.push_back(par);
        end
        stop_clks = two_stop ? ((w == 2'd0) ? 24 : 32) * dv : 16 * dv;
        repeat (stop_clks) exp_wave.push_back(1'b1);
    endfunction

    task automatic set_cfg(input logic [15:0] dv, input logic [1:0] w, input bit two_stop,
                           input bit p_en, input bit e, input bit s);
        divisor = dv; wls = w; stb = two_stop; pen = p_en; eps = e; sp = s;
    endtask

    task automatic write_byte(input logic [7:0] d, input bit hold);
        int guard = 0;
        @(negedge clk);
        bus.i_data  = d;
        bus.i_valid = 1'b1;
        while (!bus.o_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("write ready", int'(bus.o_ready), 1);
        @(posedge clk);
        #1;
        if (!hold) bus.i_valid = 1'b0;
    endtask

    // Called right after the accepting edge (or, with skip_pre, one negedge later)
    task automatic run_frame(input string name, input int exp_len, input int bc_start,
                             input int bc_len, input bit scramble, input bit skip_pre);
        int  bad = 0;
        int  first_bad = -1;
        int  temt_at = -1;
        bit  expv;
        if (!skip_pre) @(negedge clk);
        for (int k = 0; k <= exp_wave.size(); k++) begin
            @(negedge clk);
            if (k == bc_start)          bc = 1'b1;
            if (k == bc_start + bc_len) bc = 1'b0;
            if (scramble && k == 3) begin
                divisor = 16'($urandom_range(0, 5));
                wls = 2'($urandom); stb = 1'($urandom); pen = 1'($urandom);
                eps = 1'($urandom); sp = 1'($urandom);
            end
            #1;
            if (temt && temt_at < 0) temt_at = k;
            if (k == exp_par_idx) par_sample = int'(tx);
            if (k == 0)  ready0  = int'(bus.o_ready);
            if (k == 50) ready50 = int'(bus.o_ready);
            if (k < exp_wave.size()) begin
                expv = exp_wave[k] & !(k >= bc_start && k < bc_start + bc_len);
                if (tx !== expv) begin
                    bad++;
                    if (first_bad < 0) first_bad = k;
                end
            end
        end
        if (bad != 0) $display("  %s: first wrong clock %0d", name, first_bad);
        check({name, " wave errors"}, bad, 0);
        check({name, " frame clocks"}, temt_at, exp_len);
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  w;
        bit          p_en, e, s, two_stop;
        int          dv;
        int          exp_len;
        int          exp_par;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int lows;
        int temt_bad;

        vecs[0] = '{8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1, 160, 0};
        vecs[1] = '{8'h41, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 2, 320, 0};
        vecs[2] = '{8'h1F, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 120, 0};
        vecs[3] = '{8'h3C, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1, 192, 1};
        vecs[4] = '{8'h07, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 144, 0};

        bus.i_data  = 8'h00;
        bus.i_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset tx", int'(tx), 1);
        check("reset ready", int'(bus.o_ready), 1);
        check("reset thre", int'(thre), 1);
        check("reset temt", int'(temt), 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed frames from the table
        foreach (vecs[i]) begin
            set_cfg(16'(vecs[i].dv), vecs[i].w, vecs[i].two_stop, vecs[i].p_en, vecs[i].e, vecs[i].s);
            build_wave(vecs[i].data, vecs[i].w, vecs[i].p_en, vecs[i].e, vecs[i].s,
                       vecs[i].two_stop, vecs[i].dv, 1'b0);
            write_byte(vecs[i].data, 1'b0);
            run_frame($sformatf("vec%0d", i), vecs[i].exp_len, -1, 0, 1'b0, 1'b0);
            if (vecs[i].p_en) check($sformatf("vec%0d parity", i), par_sample, vecs[i].exp_par);
        end

        // Back-to-back writes with i_valid held high
        set_cfg(16'd1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        build_wave(8'h01, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        build_wave(8'h02, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        build_wave(8'h03, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        fork
            begin
                write_byte(8'h01, 1'b1);
                write_byte(8'h02, 1'b1);
                write_byte(8'h03, 1'b0);
            end
        join_none
        begin
            int guard = 0;
            @(negedge clk);
            while (temt && guard < 100) begin
                @(negedge clk);
                guard++;
            end
        end
        run_frame("b2b", 480, -1, 0, 1'b0, 1'b1);
        check("b2b ready after load", ready0, 1);
        check("b2b ready while full", ready50, 0);

        // Break held for 40 clocks mid-frame
        set_cfg(16'd1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        build_wave(8'hC3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        write_byte(8'hC3, 1'b0);
        run_frame("break", 160, 30, 40, 1'b0, 1'b0);

        // Reset during the fifth data bit of 0x55
        write_byte(8'h55, 1'b0);
        @(negedge clk);
        repeat (86) @(negedge clk);
        check("pre-reset temt", int'(temt), 0);
        rst = 1'b1;
        #1;
        check("mid-frame reset tx", int'(tx), 1);
        check("mid-frame reset temt", int'(temt), 1);
        check("mid-frame reset ready", int'(bus.o_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        lows = 0;
        temt_bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
            if (temt !== 1'b1) temt_bad++;
        end
        check("after reset tx low clocks", lows, 0);
        check("after reset temt low clocks", temt_bad, 0);

        // Divisor 0 freezes the frame in its start bit
        set_cfg(16'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        write_byte(8'hFF, 1'b0);
        @(negedge clk);
        lows = 0;
        temt_bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx === 1'b0) lows++;
            if (temt !== 1'b0) temt_bad++;
        end
        check("div0 frozen start clocks", lows, 100);
        check("div0 temt high clocks", temt_bad, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Random frames; config inputs are scrambled mid-frame
        for (int n = 0; n < 20; n++) begin
            logic [7:0]  d;
            logic [1:0]  w;
            bit          p_en, e, s, two_stop;
            int          dv;
            d = 8'($urandom); w = 2'($urandom); p_en = 1'($urandom);
            e = 1'($urandom); s = 1'($urandom); two_stop = 1'($urandom);
            dv = $urandom_range(1, 3);
            set_cfg(16'(dv), w, two_stop, p_en, e, s);
            build_wave(d, w, p_en, e, s, two_stop, dv, 1'b0);
            write_byte(d, 1'b0);
            run_frame($sformatf("rand%0d", n), exp_wave.size(), -1, 0, 1'b1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
